// File: rtl/double_adder_if.sv
// double_adder_if: strobe/acknowledge bundle for double_adder.
//   input_a, input_a_stb / input_a_ack  - operand A (binary64) handshake
//   input_b, input_b_stb / input_b_ack  - operand B (binary64) handshake
//   output_z, output_z_stb / output_z_ack - result (binary64) handshake
// The slave modport is the adder; the master modport is the producer/consumer.
interface double_adder_if;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/double_adder.sv
// double_adder: multi-cycle IEEE-754 binary64 adder, round-to-nearest-even.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - double_adder_if.slave: operand A/B capture and result Z handshakes
// Build option:
//   DOUBLE_ADDER_SUBNORMAL_EN - when defined, subnormal operands and results
//   are handled in full; otherwise subnormal inputs read as signed zero and
//   subnormal results flush to signed zero.
// Flow: GET -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORM (loop) -> ROUND
//       -> PACK -> PUT. Specials and exact cancellation jump straight to PUT.
module double_adder (
    input  logic          clk,
    input  logic          rst,
    double_adder_if.slave bus
);
    typedef enum logic [3:0] {
        GET, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT
    } state_t;

    // Working operand: sign, unbiased exponent, {hidden, 52 frac, G, R, S}.
    typedef struct packed {
        logic              s;
        logic signed [12:0] e;
        logic [55:0]       m;
    } fp_t;

    localparam logic signed [12:0] EMIN     = -13'sd1022;
    localparam logic signed [12:0] EMAX     = 13'sd1023;
    localparam logic [63:0]        QNAN_BIT = 64'h0008_0000_0000_0000;
    localparam logic [63:0]        DEF_NAN  = 64'hFFF8_0000_0000_0000;

    state_t      state;
    logic [63:0] a, b;
    logic        a_got, b_got;
    logic        a_ack, b_ack;
    logic [63:0] z_out;
    logic        z_stb;
    fp_t         ua, ub, z;

    logic        cap_a, cap_b;
    logic [56:0] sum;
    logic [53:0] rnd;
    logic        rnd_up;
    logic [10:0] efield;
    logic        spec_hit;
    logic [63:0] spec_z, pack_z;

    assign bus.input_a_ack  = a_ack;
    assign bus.input_b_ack  = b_ack;
    assign bus.output_z     = z_out;
    assign bus.output_z_stb = z_stb;

    assign cap_a = a_ack & bus.input_a_stb;
    assign cap_b = b_ack & bus.input_b_stb;

    function automatic logic is_nan(input logic [62:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic is_inf(input logic [62:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    endfunction

    function automatic logic is_zero(input logic [62:0] x);
`ifdef DOUBLE_ADDER_SUBNORMAL_EN
        return x == 63'd0;
`else
        // Subnormal operands read as zero.
        return x[62:52] == 11'd0;
`endif
    endfunction

    function automatic fp_t unpack(input logic [63:0] x);
        fp_t u;
        u.s = x[63];
        if (x[62:52] == 11'd0) begin
            u.e = EMIN;
            u.m = {1'b0, x[51:0], 3'b000};
        end else begin
            u.e = $signed({2'b00, x[62:52]}) - 13'sd1023;
            u.m = {1'b1, x[51:0], 3'b000};
        end
        return u;
    endfunction

    // Right shift keeping every shifted-out bit alive in the sticky LSB.
    function automatic logic [55:0] shr_sticky(input logic [55:0] m, input logic [12:0] d);
        logic [55:0] sh;
        logic        lost;
        if (d >= 13'd56) return {55'd0, |m};
        sh   = m >> d[5:0];
        lost = |(m << (7'd56 - {1'b0, d[5:0]}));
        return {sh[55:1], sh[0] | lost};
    endfunction

    always_comb begin
        sum    = {1'b0, ua.m} + {1'b0, ub.m};
        rnd    = {1'b0, z.m[55:3]} + 54'd1;
        rnd_up = z.m[2] & (z.m[1] | z.m[0] | z.m[3]);
        efield = 11'(z.e + 13'sd1023);

        if ($signed(z.e) > EMAX)
            pack_z = {z.s, 11'h7FF, 52'd0};
        else if (!z.m[55])
`ifdef DOUBLE_ADDER_SUBNORMAL_EN
            pack_z = {z.s, 11'd0, z.m[54:3]};
`else
            pack_z = {z.s, 63'd0};
`endif
        else
            pack_z = {z.s, efield, z.m[54:3]};

        spec_hit = 1'b1;
        spec_z   = '0;
        if (is_nan(a[62:0]))
            spec_z = a | QNAN_BIT;
        else if (is_nan(b[62:0]))
            spec_z = b | QNAN_BIT;
        else if (is_inf(a[62:0]))
            spec_z = (is_inf(b[62:0]) && (a[63] != b[63])) ? DEF_NAN : a;
        else if (is_inf(b[62:0]))
            spec_z = b;
        else if (is_zero(a[62:0]))
            // Zero sum is negative only when both zeros are negative.
            spec_z = is_zero(b[62:0]) ? {a[63] & b[63], 63'd0} : b;
        else if (is_zero(b[62:0]))
            spec_z = a;
        else
            spec_hit = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GET;
            a     <= '0;
            b     <= '0;
            a_got <= 1'b0;
            b_got <= 1'b0;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            z_out <= '0;
            z_stb <= 1'b0;
            ua    <= '0;
            ub    <= '0;
            z     <= '0;
        end else begin
            case (state)
                GET: begin
                    if (cap_a) begin
                        a     <= bus.input_a;
                        a_ack <= 1'b0;
                    end else if (!a_got) begin
                        a_ack <= 1'b1;
                    end
                    if (cap_b) begin
                        b     <= bus.input_b;
                        b_ack <= 1'b0;
                    end else if (!b_got) begin
                        b_ack <= 1'b1;
                    end
                    if ((a_got | cap_a) && (b_got | cap_b)) begin
                        a_got <= 1'b0;
                        b_got <= 1'b0;
                        state <= UNPACK;
                    end else begin
                        a_got <= a_got | cap_a;
                        b_got <= b_got | cap_b;
                    end
                end
                UNPACK: begin
                    ua    <= unpack(a);
                    ub    <= unpack(b);
                    state <= SPECIAL;
                end
                SPECIAL: begin
                    if (spec_hit) begin
                        z_out <= spec_z;
                        z_stb <= 1'b1;
                        state <= PUT;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if ($signed(ua.e) > $signed(ub.e)) begin
                        ub.m <= shr_sticky(ub.m, ua.e - ub.e);
                        ub.e <= ua.e;
                    end else if ($signed(ua.e) < $signed(ub.e)) begin
                        ua.m <= shr_sticky(ua.m, ub.e - ua.e);
                        ua.e <= ub.e;
                    end
                    state <= ADD;
                end
                ADD: begin
                    z.e <= ua.e;
                    if (ua.s == ub.s) begin
                        z.s <= ua.s;
                        if (sum[56]) begin
                            // Carry out: shift right, fold R and S into sticky.
                            z.m <= {sum[56:2], sum[1] | sum[0]};
                            z.e <= ua.e + 13'sd1;
                        end else begin
                            z.m <= sum[55:0];
                        end
                        state <= NORM;
                    end else if (ua.m == ub.m) begin
                        // Exact cancellation is always +0.
                        z_out <= '0;
                        z_stb <= 1'b1;
                        state <= PUT;
                    end else if (ua.m > ub.m) begin
                        z.s   <= ua.s;
                        z.m   <= ua.m - ub.m;
                        state <= NORM;
                    end else begin
                        z.s   <= ub.s;
                        z.m   <= ub.m - ua.m;
                        state <= NORM;
                    end
                end
                NORM: begin
                    // Stops at EMIN with MSB clear: result is subnormal.
                    if (z.m[55] || (z.e == EMIN)) begin
                        state <= ROUND;
                    end else begin
                        z.m <= z.m << 1;
                        z.e <= z.e - 13'sd1;
                    end
                end
                ROUND: begin
                    if (rnd_up) begin
                        if (rnd[53]) begin
                            z.m[55:3] <= rnd[53:1];
                            z.e       <= z.e + 13'sd1;
                        end else begin
                            z.m[55:3] <= rnd[52:0];
                        end
                    end
                    state <= PACK;
                end
                PACK: begin
                    z_out <= pack_z;
                    z_stb <= 1'b1;
                    state <= PUT;
                end
                PUT: begin
                    if (bus.output_z_ack) begin
                        z_stb <= 1'b0;
                        a_ack <= 1'b1;
                        b_ack <= 1'b1;
                        state <= GET;
                    end
                end
                default: state <= GET;
            endcase
        end
    end
endmodule

// File: tb/tb_double_adder.sv
// tb_double_adder: randomized self-checking bench for double_adder.
// The reference adds operands with the simulator's native double arithmetic
// and applies the NaN / inf-inf / zero-flush rules on top.
module tb_double_adder;
    localparam logic [63:0] SIGN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    double_adder_if bus ();

    double_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y, r;
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
        b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
        a_inf = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
        b_inf = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
        if (a_nan) return a | 64'h0008_0000_0000_0000;
        if (b_nan) return b | 64'h0008_0000_0000_0000;
        if (a_inf && b_inf && (a[63] != b[63])) return 64'hFFF8_0000_0000_0000;
        x = a;
        y = b;
`ifndef DOUBLE_ADDER_SUBNORMAL_EN
        if (x[62:52] == 0) x = {x[63], 63'd0};
        if (y[62:52] == 0) y = {y[63], 63'd0};
`endif
        r = $realtobits($bitstoreal(x) + $bitstoreal(y));
`ifndef DOUBLE_ADDER_SUBNORMAL_EN
        if (r[62:52] == 0) r = {r[63], 63'd0};
`endif
        return r;
    endfunction

    function automatic logic [63:0] rand_fp(input int base);
        int          k, t;
        logic [10:0] e;
        logic [51:0] f;
        k = int'($urandom_range(0, 15));
        f = {20'($urandom), 32'($urandom)};
        if (k < 8)       t = base + int'($urandom_range(0, 6)) - 3;
        else if (k < 11) t = int'($urandom_range(1, 2046));
        else if (k < 13) t = base + int'($urandom_range(0, 120)) - 60;
        else             t = 1;
        if (t < 1)    t = 1;
        if (t > 2046) t = 2046;
        e = 11'(t);
        if (k == 13) e = 11'd0;
        if (k == 14) begin
            e = 11'h7FF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end
        if (k == 15) begin
            e = 11'd0;
            f = '0;
        end
        return {1'($urandom), e, f};
    endfunction

    // Full A/B capture and Z hand-off. b_lag delays B's strobe; z_dly < 0
    // raises output_z_ack before the result appears. ok reports whether
    // acks, strobe and data behaved as a handshake should.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input int b_lag, input int z_dly,
                          output logic [63:0] z, output bit ok, output int lat);
        bit got_a, got_b, cap_a, cap_b;
        int n;
        got_a = 0; got_b = 0; ok = 1; lat = 0; z = '0; n = 0;
        bus.input_a = a;
        bus.input_b = b;
        bus.output_z_ack = (z_dly < 0);
        while (!(got_a && got_b)) begin
            if (!got_a && bus.input_a_ack !== 1'b1) ok = 0;
            if (!got_b && bus.input_b_ack !== 1'b1) ok = 0;
            bus.input_a_stb = !got_a;
            bus.input_b_stb = !got_b && (n >= b_lag);
            cap_a = bus.input_a_stb && bus.input_a_ack;
            cap_b = bus.input_b_stb && bus.input_b_ack;
            @(negedge clk);
            if (cap_a) begin got_a = 1; if (bus.input_a_ack !== 1'b0) ok = 0; end
            if (cap_b) begin got_b = 1; if (bus.input_b_ack !== 1'b0) ok = 0; end
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL capture_timeout: a=%h b=%h not both taken in 50 cycles", a, b);
                bus.input_a_stb = 0; bus.input_b_stb = 0; bus.output_z_ack = 0;
                return;
            end
        end
        bus.input_a_stb = 0;
        bus.input_b_stb = 0;
        while (bus.output_z_stb !== 1'b1) begin
            @(negedge clk);
            lat++;
            if (lat > 200) begin
                checks++; errors++;
                $display("FAIL result_timeout: a=%h b=%h no output_z_stb in 200 cycles", a, b);
                bus.output_z_ack = 0;
                return;
            end
        end
        z = bus.output_z;
        if (z_dly >= 0) begin
            repeat (z_dly) begin
                @(negedge clk);
                if (bus.output_z_stb !== 1'b1 || bus.output_z !== z) ok = 0;
            end
            bus.output_z_ack = 1;
        end
        @(negedge clk);
        if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1 ||
            bus.input_b_ack !== 1'b1 || bus.output_z !== z) ok = 0;
        bus.output_z_ack = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got acks/stb %b expected 000",
                     {bus.input_a_ack, bus.input_b_ack, bus.output_z_stb});
        end
        checks++;
        if (bus.output_z !== 64'd0) begin
            errors++;
            $display("FAIL reset_z: got %h expected 0", bus.output_z);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: got acks/stb %b expected 110",
                     {bus.input_a_ack, bus.input_b_ack, bus.output_z_stb});
        end
    endtask

    task automatic test_basic();
        logic [63:0] z; bit ok; int lat;
        run_op(64'h3FF0000000000000, 64'h4000000000000000, 0, 3, z, ok, lat);
        checks++;
        if (z !== 64'h4008000000000000) begin
            errors++;
            $display("FAIL basic_sum: got %h expected 4008000000000000", z);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_handshake: got ok=%0d expected 1", ok);
        end
    endtask

    task automatic test_specials();
        logic [63:0] ta [14], tb_ [14], te [14];
        logic [63:0] z; bit ok; int lat;
        ta[0]  = 64'h3FF0000000000000; tb_[0]  = 64'hBFF0000000000000; te[0]  = 64'h0;
        ta[1]  = 64'h8000000000000000; tb_[1]  = 64'h8000000000000000; te[1]  = 64'h8000000000000000;
        ta[2]  = 64'h3FF0000000000000; tb_[2]  = 64'h3CA0000000000000; te[2]  = 64'h3FF0000000000000;
        ta[3]  = 64'h3FF0000000000000; tb_[3]  = 64'h3CA0000000000001; te[3]  = 64'h3FF0000000000001;
        ta[4]  = 64'h7FEFFFFFFFFFFFFF; tb_[4]  = 64'h7FEFFFFFFFFFFFFF; te[4]  = 64'h7FF0000000000000;
        ta[5]  = 64'h7FF0000000000000; tb_[5]  = 64'hFFF0000000000000; te[5]  = 64'hFFF8000000000000;
        ta[6]  = 64'h7FF0000000000001; tb_[6]  = 64'h3FF0000000000000; te[6]  = 64'h7FF8000000000001;
        ta[7]  = 64'h0000000000000001; tb_[7]  = 64'h0000000000000001;
        ta[8]  = 64'h0000000000000000; tb_[8]  = 64'h8000000000000000; te[8]  = 64'h0;
        ta[9]  = 64'h3FF0000000000000; tb_[9]  = 64'hFFF0000000000005; te[9]  = 64'hFFF8000000000005;
        ta[10] = 64'hFFF0000000000000; tb_[10] = 64'h4000000000000000; te[10] = 64'hFFF0000000000000;
        ta[11] = 64'h8000000000000000; tb_[11] = 64'hC000000000000000; te[11] = 64'hC000000000000000;
        ta[12] = 64'h0010000000000001; tb_[12] = 64'h8010000000000000;
        ta[13] = 64'h4330000000000000; tb_[13] = 64'h3FE0000000000001; te[13] = 64'h4330000000000001;
`ifdef DOUBLE_ADDER_SUBNORMAL_EN
        te[7]  = 64'h0000000000000002;
        te[12] = 64'h0000000000000001;
`else
        te[7]  = 64'h0000000000000000;
        te[12] = 64'h0000000000000000;
`endif
        for (int i = 0; i < 14; i++) begin
            run_op(ta[i], tb_[i], i % 3, (i % 4) - 1, z, ok, lat);
            checks++;
            if (z !== te[i] || !ok) begin
                errors++;
                $display("FAIL special[%0d]: %h+%h got %h ok=%0d expected %h ok=1",
                         i, ta[i], tb_[i], z, ok, te[i]);
            end
        end
    endtask

    task automatic test_pre_ack();
        logic [63:0] z; bit ok; int lat;
        run_op(64'hC010000000000000, 64'h3FF8000000000000, 2, -1, z, ok, lat);
        checks++;
        if (z !== 64'hC004000000000000 || !ok) begin
            errors++;
            $display("FAIL pre_ack: got %h ok=%0d expected c004000000000000 ok=1", z, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] z; bit ok, seen; int lat;
        bus.input_a = 64'h3FF0000000000001;
        bus.input_b = 64'hBFF0000000000000;
        bus.input_a_stb = 1;
        bus.input_b_stb = 1;
        @(negedge clk);
        bus.input_a_stb = 0;
        bus.input_b_stb = 0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.output_z_stb !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: got stb %b expected 0 while normalising", bus.output_z_stb);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.input_a_ack, bus.input_b_ack, bus.output_z_stb} !== 3'b000 ||
            bus.output_z !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: got acks/stb %b z %h expected 000 and 0",
                     {bus.input_a_ack, bus.input_b_ack, bus.output_z_stb}, bus.output_z);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.input_a_ack, bus.input_b_ack} !== 2'b11) begin
            errors++;
            $display("FAIL mid_release: got acks %b expected 11",
                     {bus.input_a_ack, bus.input_b_ack});
        end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.output_z_stb !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_discard: got output_z_stb after reset, expected none");
        end
        run_op(64'h400921FB54442D18, 64'hC005BF0A8B145769, 1, 1, z, ok, lat);
        checks++;
        if (z !== ref_add(64'h400921FB54442D18, 64'hC005BF0A8B145769) || !ok) begin
            errors++;
            $display("FAIL mid_next: got %h ok=%0d expected %h ok=1", z, ok,
                     ref_add(64'h400921FB54442D18, 64'hC005BF0A8B145769));
        end
    endtask

    task automatic test_random(input int n);
        logic [63:0] a, b, z, exp_z;
        bit ok;
        int lat, base;
        int max_lat = 0;
        for (int i = 0; i < n; i++) begin
            base = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 64))
                                               : int'($urandom_range(1, 2046));
            a = rand_fp(base);
            b = rand_fp(base);
            case ($urandom_range(0, 9))
                0: b = a ^ SIGN;
                1: b = {~a[63], a[62:0] ^ 63'($urandom_range(0, 3))};
                default: ;
            endcase
            exp_z = ref_add(a, b);
            run_op(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)) - 1, z, ok, lat);
            checks++;
            if (z !== exp_z) begin
                errors++;
                $display("FAIL random[%0d]: %h+%h got %h expected %h", i, a, b, z, exp_z);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_handshake[%0d]: got ok=0 expected 1", i);
            end
            if (lat > max_lat) max_lat = lat;
        end
        checks++;
        if (max_lat > 120) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected at most 120", max_lat);
        end
    endtask

    initial begin
        bus.input_a      = '0;
        bus.input_b      = '0;
        bus.input_a_stb  = 1'b0;
        bus.input_b_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        test_reset();
        test_basic();
        test_specials();
        test_pre_ack();
        test_reset_mid();
        test_random(1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
